// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   fetch_state_t : fetch FSM encoding (BOOT, REQ, WAIT, HOLD)
//   ILEN_BYTES    : instruction length, used as the sequential PC step
//   RESET_VEC_DEF : default first fetch address after reset
//   is_aligned()  : true when an address is on an instruction boundary
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  localparam int unsigned ILEN_BYTES    = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Instruction holding register for the fetch controller.
// Captures the returned instruction word and keeps it stable, with its
// valid bit, until the controller drops it (consumed or redirected).
//   clk, reset  : clock, asynchronous active-high reset
//   load        : capture rdata and mark valid
//   drop        : clear valid (data is left as-is)
//   rdata       : instruction word from memory
//   instr       : held instruction word
//   instr_valid : held word is valid for decode
module fetch_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid
);

  logic [DATA_W-1:0] data_p0;
  logic              vld_p0;

  // Stage 0: memory response -> decode holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (load) begin
      data_p0 <= rdata;
      vld_p0  <= 1'b1;
    end else if (drop) begin
      vld_p0  <= 1'b0;
    end
  end

  assign instr       = data_p0;
  assign instr_valid = vld_p0;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding fetch at a time, a single
// holding register toward decode, and branch/jump redirect handling.
//   clk, reset                         : clock, asynchronous active-high reset
//   pc_cur / pc_in                     : PC register value in / next PC out
//   imem_req, imem_addr                : fetch request
//   imem_gnt, imem_rvalid, imem_rdata  : request accept / response
//   instr, instr_valid, instr_ready    : decode handshake
//   redirect_valid, redirect_target    : redirect request
//   misalign_err                       : one-cycle pulse on rejected redirect
//   fetch_cnt                          : instructions delivered to decode
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  fetch_state_t state, state_nxt;
  logic         kill, kill_nxt;
  logic         misalign_nxt;
  logic         cnt_inc;
  logic         buf_load, buf_drop;
  logic         redir_ok, redir_bad;

  assign redir_ok  = redirect_valid &  is_aligned(redirect_target);
  assign redir_bad = redirect_valid & ~is_aligned(redirect_target);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_BOOT;
      kill         <= 1'b0;
      misalign_err <= 1'b0;
      fetch_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      kill         <= kill_nxt;
      misalign_err <= misalign_nxt;
      if (cnt_inc) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  // Next-state logic. A misaligned redirect behaves as no redirect at all,
  // apart from the error pulse (suppressed in BOOT).
  always_comb begin
    state_nxt    = state;
    kill_nxt     = kill;
    misalign_nxt = redir_bad && (state != ST_BOOT);
    cnt_inc      = 1'b0;
    buf_load     = 1'b0;
    buf_drop     = 1'b0;
    case (state)
      ST_BOOT: state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) begin
          state_nxt = ST_WAIT;
          // Request went out for the old PC; its response must be dropped.
          kill_nxt  = redir_ok;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          kill_nxt  = 1'b0;
          state_nxt = ST_REQ;
          if (!kill && !redir_ok) begin
            buf_load  = 1'b1;
            state_nxt = ST_HOLD;
          end
        end else if (redir_ok) begin
          kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        // Redirect wins over a simultaneous consume: no count, word dropped.
        if (redir_ok) begin
          buf_drop  = 1'b1;
          state_nxt = ST_REQ;
        end else if (instr_ready) begin
          buf_drop  = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    pc_in     = pc_cur;
    imem_req  = 1'b0;
    imem_addr = '0;
    case (state)
      ST_BOOT: pc_in = RESET_VEC;
      ST_REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_cur;
        if (redir_ok) pc_in = redirect_target;
      end
      ST_WAIT: begin
        if (redir_ok) pc_in = redirect_target;
      end
      ST_HOLD: begin
        if (redir_ok)         pc_in = redirect_target;
        else if (instr_ready) pc_in = pc_cur + 32'(ILEN_BYTES);
      end
      default: pc_in = RESET_VEC;
    endcase
  end

  fetch_buf #(
    .DATA_W(32)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .drop       (buf_drop),
    .rdata      (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid)
  );

endmodule
